alarm_ring: RTL and testbench
=============================

# alarm_ring

Consumer side of the alarm-time registers: compares the BCD alarm setting against the running BCD clock and drives the buzzer. Sits between the time counter / alarm-setting logic and the board buzzer pin. Contains a RING/SNOOZE state machine, second-based duration counters, debounced stop/snooze keys and a square-wave tone generator. An optional top-of-hour chime is also included.

## Interface
- CLK_HZ, 50_000_000: clk frequency in Hz.
- TONE_HZ, 1000: buzzer tone frequency; half-period = CLK_HZ/(2*TONE_HZ) cycles (integer divide).
- RING_SEC, 60: ring duration in sec_tick pulses (1..255).
- SNOOZE_SEC, 300: snooze duration in sec_tick pulses (1..1023).
- DEB_MS, 20: key debounce time; DEB_CYC = CLK_HZ/1000*DEB_MS cycles.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- sec_tick  in  1  one-cycle pulse per second from the time counter; cur_* are valid in that cycle.
- cur_hour  in  8  BCD hour 00–23.
- cur_minute  in  8  BCD minute 00–59.
- cur_second  in  8  BCD second 00–59.
- alarm_hour  in  8  BCD alarm hour.
- alarm_minute  in  8  BCD alarm minute.
- alarm_en  in  1  level; alarm armed when high.
- key_stop  in  1  raw key, active-low, asynchronous.
- key_snooze  in  1  raw key, active-low, asynchronous.
- buzzer  out  1  buzzer drive.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- chime  out  1  high while the hourly chime sounds (0 when the feature is compiled out).

## Operation
- Key path: 2-FF synchronizer, then a debouncer. A press pulse (1 cycle) is emitted once the synced key has been stable low for DEB_CYC cycles. It re-arms only after the key has been stable high for DEB_CYC cycles. Exactly one pulse is produced per press.
- Match = sec_tick & alarm_en & cur_hour==alarm_hour & cur_minute==alarm_minute & cur_second==8'h00. This is an 8-bit exact BCD compare; there is no BCD validity check.
- FSM states: IDLE, RING, SNOOZE. Reset state is IDLE.
- IDLE -> RING on match. Entering RING loads ring_cnt=RING_SEC and sets gate=1.
- In RING:
  - Each sec_tick decrements ring_cnt and toggles gate.
  - On the tick where ring_cnt==1, go to IDLE.
  - Stop pulse -> IDLE.
  - Snooze pulse -> SNOOZE, loading snz_cnt=SNOOZE_SEC.
- In SNOOZE:
  - Each sec_tick decrements snz_cnt.
  - On the tick where snz_cnt==1, go to RING with a fresh RING_SEC and gate=1.
  - Stop pulse -> IDLE.
- alarm_en low forces IDLE from any state, and takes priority over everything.
- Priority within a cycle: alarm_en low > stop > snooze > tick expiry > match.
- Match while in RING or SNOOZE is ignored; it does not restart the counters.
- Tone: a free-running divider toggles tone every half-period. buzzer = (RING & gate & tone) | (chime & tone).

## Timing
- Reset values: buzzer=0, ringing=0, snoozing=0, chime=0, tone=0, gate=0, counters=0, debouncers idle (key considered released).
- All outputs are registered, including buzzer.
- ringing rises on the clock edge that samples the matching sec_tick, i.e. 1 cycle of latency.
- A key press becomes visible in state 2 (sync) + DEB_CYC + 1 cycles after the raw key falls.
- RING lasts exactly RING_SEC sec_tick pulses after the entry tick.
- Reset asserted mid-RING or mid-SNOOZE clears the outputs immediately (asynchronously) and returns to IDLE.

## Configuration
- HOUR_CHIME_EN defined:
  - On a sec_tick with cur_minute==8'h00, cur_second==8'h00 and state IDLE, chime goes high for 2 sec_tick pulses.
  - An alarm match during the chime clears chime and enters RING; the alarm wins.
- HOUR_CHIME_EN undefined: no chime logic; chime is tied to 0.

## Test plan
Bench parameters: CLK_HZ=1000, TONE_HZ=100 (half-period 5 cycles), RING_SEC=5, SNOOZE_SEC=3, DEB_MS=2.
- Alarm 07:30, en=1; tick at 07:30:00 -> ringing=1 next cycle; buzzer toggles every 5 cycles with gate alternating per tick; ringing=0 after the 5th subsequent tick.
- Ringing; hold key_snooze low for 10 cycles -> snoozing=1, one pulse only; after 3 ticks -> ringing=1 again for 5 ticks.
- Ringing; key_stop and key_snooze pressed in the same cycle -> IDLE, snoozing stays 0.
- Ringing; alarm_en driven 0 -> ringing=0 next cycle. Separately, a tick at 07:30:00 with en=0 -> no ring.
- rst_n pulsed low during SNOOZE -> all outputs 0 immediately, state IDLE; no ring after release.
- HOUR_CHIME_EN defined: tick at 08:00:00 -> chime=1 for 2 ticks. With alarm 08:00 set -> ringing=1, chime=0.

Source files
------------

// File: rtl/alarm_ring.sv
// alarm_ring: compares the BCD alarm setting with the running clock and
// drives the buzzer. RING/SNOOZE state machine with second-based counters,
// debounced stop/snooze keys and a square-wave tone generator.
// Optional top-of-hour chime: define HOUR_CHIME_EN to build it in;
// when undefined, chime is tied low.

// Per-key front end: 2-FF synchronizer, then a debouncer that emits one
// press pulse after DEB_CYC stable-low cycles and re-arms only after
// DEB_CYC stable-high cycles.
module alarm_ring_key #(
  parameter int DEB_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);
  localparam int DC = (DEB_CYC < 1) ? 1 : DEB_CYC;
  localparam int CW = $clog2(DC + 1);
  localparam logic [CW-1:0] LAST = CW'(DC - 1);

  logic [1:0]    sync_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // Two-stage synchronizer; resets to "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n_i};
  end

  // armed_q=1 waits for a stable press, armed_q=0 waits for a stable release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (armed_q) begin
        if (!sync_q[1]) begin
          if (cnt_q == LAST) begin
            press_q <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end else begin
        if (sync_q[1]) begin
          if (cnt_q == LAST) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign press_o = press_q;
endmodule

module alarm_ring #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TONE_HZ    = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int DEB_MS     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_minute,
  input  logic       alarm_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic       chime
);
  localparam int HALF    = CLK_HZ / (2 * TONE_HZ);
  localparam int HALF_C  = (HALF < 1) ? 1 : HALF;
  localparam int TW      = $clog2(HALF_C + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_C - 1);
  localparam int DEB_CYC = CLK_HZ / 1000 * DEB_MS;
  localparam logic [7:0] RING_L = 8'(RING_SEC);
  localparam logic [9:0] SNZ_L  = 10'(SNOOZE_SEC);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    ring_q, ring_d;
  logic [9:0]    snz_q, snz_d;
  logic          gate_q, gate_d;
  logic [TW-1:0] tdiv_q, tdiv_d;
  logic          tone_q, tone_d;
  logic          chime_q, chime_d;
  logic          ringing_q, snoozing_q, buzzer_q;
  logic          stop_p, snz_p, match, enter_ring;

  alarm_ring_key #(.DEB_CYC(DEB_CYC)) u_key_stop (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_stop), .press_o(stop_p)
  );
  alarm_ring_key #(.DEB_CYC(DEB_CYC)) u_key_snz (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_snooze), .press_o(snz_p)
  );

  // Exact 8-bit BCD compare; no validity check on the digits
  assign match = sec_tick & alarm_en & (cur_hour == alarm_hour) &
                 (cur_minute == alarm_minute) & (cur_second == 8'h00);

  // Free-running tone divider: toggle every half-period
  always_comb begin
    tdiv_d = tdiv_q + 1'b1;
    tone_d = tone_q;
    if (tdiv_q == HALF_LAST) begin
      tdiv_d = '0;
      tone_d = ~tone_q;
    end
  end

  // Next-state: alarm_en low > stop > snooze > tick expiry > match
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    gate_d  = gate_q;
    if (!alarm_en) begin
      state_d = S_IDLE;
      ring_d  = '0;
      snz_d   = '0;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match) begin
            state_d = S_RING;
            ring_d  = RING_L;
            gate_d  = 1'b1;
          end
        end
        S_RING: begin
          if (stop_p) begin
            state_d = S_IDLE;
            ring_d  = '0;
            gate_d  = 1'b0;
          end else if (snz_p) begin
            state_d = S_SNOOZE;
            snz_d   = SNZ_L;
            ring_d  = '0;
            gate_d  = 1'b0;
          end else if (sec_tick) begin
            if (ring_q == 8'd1) begin
              state_d = S_IDLE;
              ring_d  = '0;
              gate_d  = 1'b0;
            end else begin
              ring_d = ring_q - 8'd1;
              gate_d = ~gate_q;
            end
          end
        end
        S_SNOOZE: begin
          if (stop_p) begin
            state_d = S_IDLE;
            snz_d   = '0;
          end else if (sec_tick) begin
            if (snz_q == 10'd1) begin
              state_d = S_RING;
              snz_d   = '0;
              ring_d  = RING_L;
              gate_d  = 1'b1;
            end else begin
              snz_d = snz_q - 10'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          ring_d  = '0;
          snz_d   = '0;
          gate_d  = 1'b0;
        end
      endcase
    end
  end

  assign enter_ring = (state_q == S_IDLE) && (state_d == S_RING);

`ifdef HOUR_CHIME_EN
  logic [1:0] chm_q, chm_d;

  // Hourly chime for 2 ticks; an alarm entering RING cancels it
  always_comb begin
    chime_d = chime_q;
    chm_d   = chm_q;
    if (enter_ring) begin
      chime_d = 1'b0;
      chm_d   = '0;
    end else if (chime_q && sec_tick) begin
      if (chm_q == 2'd1) begin
        chime_d = 1'b0;
        chm_d   = '0;
      end else begin
        chm_d = chm_q - 2'd1;
      end
    end else if (!chime_q && sec_tick && state_q == S_IDLE &&
                 cur_minute == 8'h00 && cur_second == 8'h00) begin
      chime_d = 1'b1;
      chm_d   = 2'd2;
    end
  end

  // Chime tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chm_q <= '0;
    else        chm_q <= chm_d;
  end
`else
  assign chime_d = 1'b0;
`endif

  // State, counters and registered outputs (computed from next-state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ring_q     <= '0;
      snz_q      <= '0;
      gate_q     <= 1'b0;
      tdiv_q     <= '0;
      tone_q     <= 1'b0;
      chime_q    <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_q     <= ring_d;
      snz_q      <= snz_d;
      gate_q     <= gate_d;
      tdiv_q     <= tdiv_d;
      tone_q     <= tone_d;
      chime_q    <= chime_d;
      ringing_q  <= (state_d == S_RING);
      snoozing_q <= (state_d == S_SNOOZE);
      buzzer_q   <= ((state_d == S_RING) & gate_d & tone_d) | (chime_d & tone_d);
    end
  end

  assign buzzer   = buzzer_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;
  assign chime    = chime_q;
endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring: CLK_HZ=1000, TONE_HZ=100 (half-period 5),
// RING_SEC=5, SNOOZE_SEC=3, DEB_MS=2 (DEB_CYC=2).
module tb_alarm_ring;
  logic       clk = 1'b0;
  logic       rst_n, sec_tick, alarm_en, key_stop, key_snooze;
  logic [7:0] cur_hour, cur_minute, cur_second, alarm_hour, alarm_minute;
  logic       buzzer, ringing, snoozing, chime;
  int         errors = 0;
  int         checks = 0;

  alarm_ring #(.CLK_HZ(1000), .TONE_HZ(100), .RING_SEC(5), .SNOOZE_SEC(3), .DEB_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_en(alarm_en),
    .key_stop(key_stop), .key_snooze(key_snooze),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .chime(chime)
  );

  always #5 clk = ~clk;

  // Advance n active edges and land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour = h; cur_minute = m; cur_second = s;
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic press_keys(input logic stop, input logic snz);
    key_stop = ~stop; key_snooze = ~snz;
    step(10);
    key_stop = 1'b1; key_snooze = 1'b1;
    step(6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0;
    key_stop = 1'b1; key_snooze = 1'b1;
    cur_hour = 8'h00; cur_minute = 8'h00; cur_second = 8'h00;
    alarm_hour = 8'h07; alarm_minute = 8'h30;
    step(3);
    checks++; if ({buzzer, ringing, snoozing, chime} !== 4'b0000) begin errors++;
      $display("FAIL reset_outputs: got %b want 0000", {buzzer, ringing, snoozing, chime}); end
    rst_n = 1'b1;
    alarm_en = 1'b1;
    step(2);
  endtask

  task automatic test_ring;
    int n; logic prev; int ones;
    send_tick(8'h07, 8'h29, 8'h59);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL ring_pre: ringing=%b want 0", ringing); end
    send_tick(8'h07, 8'h30, 8'h00);
    checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL ring_entry: ringing=%b want 1", ringing); end
    n = 0; prev = buzzer;
    for (int i = 0; i < 20; i++) begin step(1); if (buzzer !== prev) n++; prev = buzzer; end
    checks++; if (n !== 4) begin errors++; $display("FAIL ring_tone_gate1: toggles=%0d want 4", n); end
    send_tick(8'h07, 8'h30, 8'h01);
    n = 0; ones = 0; prev = buzzer;
    for (int i = 0; i < 20; i++) begin step(1); if (buzzer !== prev) n++; if (buzzer) ones++; prev = buzzer; end
    checks++; if (n !== 0 || ones !== 0) begin errors++;
      $display("FAIL ring_gate0_silent: toggles=%0d highs=%0d want 0 0", n, ones); end
    send_tick(8'h07, 8'h30, 8'h02);
    n = 0; prev = buzzer;
    for (int i = 0; i < 20; i++) begin step(1); if (buzzer !== prev) n++; prev = buzzer; end
    checks++; if (n !== 4) begin errors++; $display("FAIL ring_tone_gate2: toggles=%0d want 4", n); end
    send_tick(8'h07, 8'h30, 8'h03);
    send_tick(8'h07, 8'h30, 8'h04);
    checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL ring_after4: ringing=%b want 1", ringing); end
    send_tick(8'h07, 8'h30, 8'h05);
    checks++; if ({ringing, buzzer} !== 2'b00) begin errors++;
      $display("FAIL ring_end5: ringing,buzzer=%b want 00", {ringing, buzzer}); end
  endtask

  task automatic test_snooze;
    send_tick(8'h07, 8'h30, 8'h00);
    key_snooze = 1'b0;
    step(4);
    checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL snz_latency_early: snoozing=%b want 0", snoozing); end
    step(1);
    checks++; if ({snoozing, ringing} !== 2'b10) begin errors++;
      $display("FAIL snz_enter: snoozing,ringing=%b want 10", {snoozing, ringing}); end
    step(5);
    key_snooze = 1'b1;
    step(6);
    checks++; if ({snoozing, buzzer} !== 2'b10) begin errors++;
      $display("FAIL snz_hold: snoozing,buzzer=%b want 10", {snoozing, buzzer}); end
    send_tick(8'h07, 8'h30, 8'h11);
    send_tick(8'h07, 8'h30, 8'h12);
    checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snz_after2: snoozing=%b want 1", snoozing); end
    send_tick(8'h07, 8'h30, 8'h13);
    checks++; if ({ringing, snoozing} !== 2'b10) begin errors++;
      $display("FAIL snz_rering: ringing,snoozing=%b want 10", {ringing, snoozing}); end
    for (int i = 0; i < 4; i++) send_tick(8'h07, 8'h30, 8'h14);
    checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL rering_after4: ringing=%b want 1", ringing); end
    send_tick(8'h07, 8'h30, 8'h15);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL rering_end5: ringing=%b want 0", ringing); end
  endtask

  task automatic test_stop_and_snooze;
    send_tick(8'h07, 8'h30, 8'h00);
    press_keys(1'b1, 1'b1);
    checks++; if ({ringing, snoozing} !== 2'b00) begin errors++;
      $display("FAIL stop_snz_same: ringing,snoozing=%b want 00", {ringing, snoozing}); end
  endtask

  task automatic test_stop_in_snooze;
    send_tick(8'h07, 8'h30, 8'h00);
    press_keys(1'b0, 1'b1);
    checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL stop_snz_pre: snoozing=%b want 1", snoozing); end
    press_keys(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_tick(8'h07, 8'h30, 8'h20);
    checks++; if ({ringing, snoozing} !== 2'b00) begin errors++;
      $display("FAIL stop_in_snooze: ringing,snoozing=%b want 00", {ringing, snoozing}); end
  endtask

  task automatic test_alarm_en;
    send_tick(8'h07, 8'h30, 8'h00);
    alarm_en = 1'b0;
    step(1);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL en_low_stop: ringing=%b want 0", ringing); end
    send_tick(8'h07, 8'h30, 8'h00);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL en_low_nomatch: ringing=%b want 0", ringing); end
    alarm_en = 1'b1;
    step(1);
  endtask

  task automatic test_match_ignored;
    send_tick(8'h07, 8'h30, 8'h00);
    send_tick(8'h07, 8'h30, 8'h01);
    send_tick(8'h07, 8'h30, 8'h00);
    send_tick(8'h07, 8'h30, 8'h02);
    send_tick(8'h07, 8'h30, 8'h03);
    send_tick(8'h07, 8'h30, 8'h04);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL match_in_ring_ignored: ringing=%b want 0", ringing); end
  endtask

  task automatic test_no_match;
    send_tick(8'h07, 8'h30, 8'h01);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL nomatch_sec: ringing=%b want 0", ringing); end
    send_tick(8'h07, 8'h31, 8'h00);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL nomatch_min: ringing=%b want 0", ringing); end
    send_tick(8'h06, 8'h30, 8'h00);
    checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL nomatch_hour: ringing=%b want 0", ringing); end
  endtask

  task automatic test_reset_mid_snooze;
    send_tick(8'h07, 8'h30, 8'h00);
    press_keys(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if ({buzzer, ringing, snoozing, chime} !== 4'b0000) begin errors++;
      $display("FAIL reset_async: got %b want 0000", {buzzer, ringing, snoozing, chime}); end
    step(2);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) send_tick(8'h07, 8'h30, 8'h05);
    checks++; if ({ringing, snoozing} !== 2'b00) begin errors++;
      $display("FAIL reset_then_idle: ringing,snoozing=%b want 00", {ringing, snoozing}); end
  endtask

  task automatic test_chime;
`ifdef HOUR_CHIME_EN
    send_tick(8'h08, 8'h00, 8'h00);
    checks++; if (chime !== 1'b1) begin errors++; $display("FAIL chime_start: chime=%b want 1", chime); end
    send_tick(8'h08, 8'h00, 8'h01);
    checks++; if (chime !== 1'b1) begin errors++; $display("FAIL chime_tick1: chime=%b want 1", chime); end
    send_tick(8'h08, 8'h00, 8'h02);
    checks++; if (chime !== 1'b0) begin errors++; $display("FAIL chime_end: chime=%b want 0", chime); end
    alarm_hour = 8'h08; alarm_minute = 8'h00;
    send_tick(8'h08, 8'h00, 8'h00);
    checks++; if ({ringing, chime} !== 2'b10) begin errors++;
      $display("FAIL chime_alarm_wins: ringing,chime=%b want 10", {ringing, chime}); end
    press_keys(1'b1, 1'b0);
    alarm_hour = 8'h07; alarm_minute = 8'h30;
`else
    send_tick(8'h08, 8'h00, 8'h00);
    checks++; if (chime !== 1'b0) begin errors++; $display("FAIL chime_off: chime=%b want 0", chime); end
`endif
  endtask

  initial begin
    test_reset;
    test_ring;
    test_snooze;
    test_stop_and_snooze;
    test_stop_in_snooze;
    test_alarm_en;
    test_match_ignored;
    test_no_match;
    test_reset_mid_snooze;
    test_chime;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
